// File: rtl/ysyx_25040109_csr_pkg.sv
// Shared CSR addresses, csr_op encodings, mstatus field positions and reset values.
// YSYX_MCYCLE_EN adds the mcycle/mcycleh addresses.
package ysyx_25040109_csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef YSYX_MCYCLE_EN
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
`endif

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
  localparam logic [31:0] MTVEC_RST   = 32'h0000_0000;
  localparam logic [31:0] MEPC_RST    = 32'h0000_0000;
  localparam logic [31:0] MCAUSE_RST  = 32'h0000_0000;

  function automatic logic [31:0] csr_alu(input csr_op_e op, input logic [31:0] old_val,
                                          input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_WRITE: res = src;
      CSR_OP_SET:   res = old_val | src;
      CSR_OP_CLEAR: res = old_val & ~src;
      default:      res = old_val;
    endcase
    return res;
  endfunction

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] val;
    val = '0;
    val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    val[MSTATUS_MPIE] = mpie;
    val[MSTATUS_MIE]  = mie;
    return val;
  endfunction

endpackage

// File: rtl/ysyx_25040109_csr_file.sv
// Machine-mode CSR file: op ALU, trap entry / mret sequencing.
// YSYX_MCYCLE_EN adds the free-running 64-bit mcycle counter.
module ysyx_25040109_csr_file
  import ysyx_25040109_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_src_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_valid_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  csr_op_e     op;
  logic        hit;
  logic        csr_we;
  logic [31:0] old_val;
  logic [31:0] new_val;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

`ifdef YSYX_MCYCLE_EN
  logic [63:0] mcycle_q, mcycle_d;
`endif

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS: old_val = mstatus_pack(mie_q, mpie_q);
      CSR_MTVEC:   old_val = mtvec_q;
      CSR_MEPC:    old_val = mepc_q;
      CSR_MCAUSE:  old_val = mcause_q;
`ifdef YSYX_MCYCLE_EN
      CSR_MCYCLE:  old_val = mcycle_q[31:0];
      CSR_MCYCLEH: old_val = mcycle_q[63:32];
`endif
      default:     hit = 1'b0;
    endcase
  end

  // A trap or mret in the same cycle swallows the software CSR update.
  assign csr_we        = (op != CSR_OP_NONE) && hit && !trap_valid_i && !mret_valid_i;
  assign new_val       = csr_alu(op, old_val, csr_src_i);
  assign csr_rdata_o   = old_val;
  assign csr_illegal_o = (op != CSR_OP_NONE) && !hit;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;

  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_valid_i) begin
      mepc_d   = {trap_pc_i[31:2], 2'b00};
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_valid_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:  mtvec_d  = {new_val[31:2], 2'b00};
        CSR_MEPC:   mepc_d   = {new_val[31:2], 2'b00};
        CSR_MCAUSE: mcause_d = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= MSTATUS_RST[MSTATUS_MIE];
      mpie_q   <= MSTATUS_RST[MSTATUS_MPIE];
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= MEPC_RST;
      mcause_q <= MCAUSE_RST;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

`ifdef YSYX_MCYCLE_EN
  // A write to one half replaces it and freezes the other half (no carry that cycle).
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (csr_we && (csr_addr_i == CSR_MCYCLE))
      mcycle_d = {mcycle_q[63:32], new_val};
    else if (csr_we && (csr_addr_i == CSR_MCYCLEH))
      mcycle_d = {new_val, mcycle_q[31:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcycle_q <= '0;
    else        mcycle_q <= mcycle_d;
  end
`endif

endmodule

// File: rtl/ysyx_25040109_regfile_csr_v2.sv
// GPR file with write bypass and busy-bit scoreboard, plus the machine-mode CSR file.
// Optional mcycle/mcycleh counters are enabled with YSYX_MCYCLE_EN.
module ysyx_25040109_regfile_csr_v2
  import ysyx_25040109_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rbusy,
  input  logic                             iss_valid,
  input  logic [ADDR_WIDTH-1:0]            iss_rd,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [1:0]                       csr_op,
  input  logic [11:0]                      csr_addr,
  input  logic [DATA_WIDTH-1:0]            csr_src,
  output logic [DATA_WIDTH-1:0]            csr_rdata,
  output logic                             csr_illegal,
  input  logic                             trap_valid,
  input  logic [31:0]                      trap_pc,
  input  logic [DATA_WIDTH-1:0]            trap_cause,
  input  logic                             mret_valid,
  output logic [31:0]                      mtvec_out,
  output logic [31:0]                      mepc_out
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr_q [NREGS];
  logic [NREGS-1:0]      busy_q, busy_d;
  logic                  gpr_we;

  assign gpr_we = wen && (waddr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      logic                  byp;
      assign ra  = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign byp = gpr_we && (waddr == ra);
      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : (byp ? wdata : gpr_q[ra]);
      // The bypassed writeback is the one the reader was waiting for.
      assign rbusy[gi] = (ra != '0) && !byp && busy_q[ra];
    end
  endgenerate

  always_comb begin
    busy_d = busy_q;
    if (gpr_we)
      busy_d[waddr] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        gpr_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (gpr_we)
        gpr_q[waddr] <= wdata;
      busy_q <= busy_d;
    end
  end

  ysyx_25040109_csr_file u_csr (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_op_i      (csr_op),
    .csr_addr_i    (csr_addr),
    .csr_src_i     (csr_src),
    .csr_rdata_o   (csr_rdata),
    .csr_illegal_o (csr_illegal),
    .trap_valid_i  (trap_valid),
    .trap_pc_i     (trap_pc),
    .trap_cause_i  (trap_cause),
    .mret_valid_i  (mret_valid),
    .mtvec_o       (mtvec_out),
    .mepc_o        (mepc_out)
  );

endmodule

// File: tb/tb_ysyx_25040109_regfile_csr_v2.sv
// Directed scoreboard bench for ysyx_25040109_regfile_csr_v2 (GPR, scoreboard, CSR, trap/mret).
module tb_ysyx_25040109_regfile_csr_v2;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  localparam int S_RDATA0 = 0, S_RDATA1 = 1, S_RBUSY0 = 2, S_RBUSY1 = 3;
  localparam int S_CSR = 4, S_ILL = 5, S_MTVEC = 6, S_MEPC = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             iss_valid = 1'b0;
  logic [AW-1:0]    iss_rd = '0;
  logic             wen = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [1:0]       csr_op = 2'b00;
  logic [11:0]      csr_addr = 12'h000;
  logic [DW-1:0]    csr_src = '0;
  logic [DW-1:0]    csr_rdata;
  logic             csr_illegal;
  logic             trap_valid = 1'b0;
  logic [31:0]      trap_pc = '0;
  logic [DW-1:0]    trap_cause = '0;
  logic             mret_valid = 1'b0;
  logic [31:0]      mtvec_out;
  logic [31:0]      mepc_out;

  always #5 clk = ~clk;

  ysyx_25040109_regfile_csr_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wen(wen), .waddr(waddr), .wdata(wdata),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_src(csr_src), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .mret_valid(mret_valid), .mtvec_out(mtvec_out),
    .mepc_out(mepc_out)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RDATA0: return rdata[0 +: DW];
      S_RDATA1: return rdata[DW +: DW];
      S_RBUSY0: return {31'b0, rbusy[0]};
      S_RBUSY1: return {31'b0, rbusy[1]};
      S_CSR:    return csr_rdata;
      S_ILL:    return {31'b0, csr_illegal};
      S_MTVEC:  return mtvec_out;
      S_MEPC:   return mepc_out;
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] exp, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    #1;
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] obs;
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; iss_valid = 1'b0; csr_op = 2'b00; trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic set_raddr(input int k, input logic [AW-1:0] idx);
    raddr[k*AW +: AW] = idx;
  endtask

  initial begin
    // Reset state
    #2;
    set_raddr(0, 5); csr_addr = 12'h300;
    expect_val(S_CSR, 32'h0000_1800, "rst_mstatus");
    expect_val(S_MTVEC, 32'h0, "rst_mtvec");
    expect_val(S_MEPC, 32'h0, "rst_mepc");
    expect_val(S_RDATA0, 32'h0, "rst_x5");
    expect_val(S_RBUSY0, 32'h0, "rst_busy5");
    drain();
    tick();
    rst_n = 1'b1;
    tick();

    // Bypass
    wen = 1'b1; waddr = 7; wdata = 32'hDEAD_BEEF; set_raddr(0, 7);
    expect_val(S_RDATA0, 32'hDEAD_BEEF, "bypass_x7");
    expect_val(S_RBUSY0, 32'h0, "bypass_busy7");
    drain(); tick(); idle();
    expect_val(S_RDATA0, 32'hDEAD_BEEF, "stored_x7");
    drain();

    // x0 is hardwired
    wen = 1'b1; waddr = 0; wdata = 32'h55; set_raddr(0, 0);
    expect_val(S_RDATA0, 32'h0, "x0_bypass");
    drain(); tick(); idle();
    expect_val(S_RDATA0, 32'h0, "x0_after");
    drain();

    // Scoreboard set / clear
    iss_valid = 1'b1; iss_rd = 10;
    tick(); idle();
    set_raddr(1, 10);
    expect_val(S_RBUSY1, 32'h1, "busy10_set");
    drain();
    wen = 1'b1; waddr = 10; wdata = 32'h42;
    expect_val(S_RBUSY1, 32'h0, "busy10_wb_same");
    expect_val(S_RDATA1, 32'h42, "x10_wb_bypass");
    drain(); tick(); idle();
    expect_val(S_RBUSY1, 32'h0, "busy10_clear");
    expect_val(S_RDATA1, 32'h42, "x10_stored");
    drain();
    iss_valid = 1'b1; iss_rd = 3; wen = 1'b1; waddr = 3; wdata = 32'h9;
    tick(); idle();
    set_raddr(0, 3);
    expect_val(S_RBUSY0, 32'h1, "busy3_set_wins");
    expect_val(S_RDATA0, 32'h9, "x3_written");
    drain();

    // CSR ops
    csr_op = 2'b01; csr_addr = 12'h305; csr_src = 32'h8000_0103;
    expect_val(S_CSR, 32'h0, "mtvec_old");
    expect_val(S_ILL, 32'h0, "mtvec_legal");
    drain(); tick(); idle();
    expect_val(S_CSR, 32'h8000_0100, "mtvec_read");
    expect_val(S_MTVEC, 32'h8000_0100, "mtvec_out");
    drain();
    csr_op = 2'b10; csr_addr = 12'h300; csr_src = 32'h8;
    tick(); idle();
    expect_val(S_CSR, 32'h0000_1808, "csrs_mstatus");
    drain();
    csr_op = 2'b11; csr_src = 32'h8;
    tick(); idle();
    expect_val(S_CSR, 32'h0000_1800, "csrc_mstatus");
    drain();
    csr_op = 2'b01; csr_src = 32'hFFFF_FFFF;
    tick(); idle();
    expect_val(S_CSR, 32'h0000_1888, "mstatus_wmask");
    drain();
    csr_op = 2'b01; csr_src = 32'h0000_0008;
    tick(); idle();
    expect_val(S_CSR, 32'h0000_1808, "mstatus_mie_only");
    drain();
    csr_op = 2'b01; csr_addr = 12'h341; csr_src = 32'h8000_0043;
    tick(); idle();
    expect_val(S_MEPC, 32'h8000_0040, "mepc_align");
    drain();
    csr_op = 2'b01; csr_addr = 12'h123; csr_src = 32'hFFFF_FFFF;
    expect_val(S_ILL, 32'h1, "illegal_123");
    expect_val(S_CSR, 32'h0, "illegal_rdata");
    drain();
    csr_op = 2'b00;
    expect_val(S_ILL, 32'h0, "no_op_legal");
    drain();

    // Trap wins over a same-cycle CSR write to mepc
    csr_op = 2'b01; csr_addr = 12'h341; csr_src = 32'h1234_5678;
    trap_valid = 1'b1; trap_pc = 32'h8000_0040; trap_cause = 32'd11;
    expect_val(S_MTVEC, 32'h8000_0100, "trap_target");
    drain(); tick(); idle();
    expect_val(S_MEPC, 32'h8000_0040, "trap_mepc");
    drain();
    csr_addr = 12'h342;
    expect_val(S_CSR, 32'd11, "trap_mcause");
    drain();
    csr_addr = 12'h300;
    expect_val(S_CSR, 32'h0000_1880, "trap_mstatus");
    drain();
    mret_valid = 1'b1; csr_op = 2'b01; csr_src = 32'h0;
    tick(); idle();
    expect_val(S_CSR, 32'h0000_1888, "mret_mstatus");
    drain();

`ifdef YSYX_MCYCLE_EN
    csr_op = 2'b01; csr_addr = 12'hB00; csr_src = 32'hFFFF_FFFE;
    tick(); idle();
    expect_val(S_CSR, 32'hFFFF_FFFE, "mcycle_written");
    drain();
    tick(); tick();
    expect_val(S_CSR, 32'h0, "mcycle_wrapped");
    drain();
    csr_addr = 12'hB80;
    expect_val(S_CSR, 32'h1, "mcycleh_carry");
    drain();
    csr_op = 2'b01; csr_src = 32'h5;
    tick(); idle();
    expect_val(S_CSR, 32'h5, "mcycleh_written");
    drain();
    csr_addr = 12'hB00;
    expect_val(S_CSR, 32'h0, "mcycle_held");
    drain();
`else
    csr_op = 2'b10; csr_addr = 12'hB00; csr_src = 32'h0;
    expect_val(S_ILL, 32'h1, "mcycle_illegal");
    expect_val(S_CSR, 32'h0, "mcycle_read0");
    drain(); tick(); idle();
`endif

    // Asynchronous reset mid-run
    wen = 1'b1; waddr = 5; wdata = 32'h1234;
    csr_op = 2'b01; csr_addr = 12'h305; csr_src = 32'h8000_0100;
    tick(); idle();
    set_raddr(0, 5); set_raddr(1, 3); csr_addr = 12'h300;
    expect_val(S_RDATA0, 32'h1234, "x5_before_rst");
    expect_val(S_MTVEC, 32'h8000_0100, "mtvec_before_rst");
    expect_val(S_RBUSY1, 32'h1, "busy3_before_rst");
    drain();
    rst_n = 1'b0;
    expect_val(S_RDATA0, 32'h0, "x5_async_rst");
    expect_val(S_MTVEC, 32'h0, "mtvec_async_rst");
    expect_val(S_CSR, 32'h0000_1800, "mstatus_async_rst");
    expect_val(S_RBUSY1, 32'h0, "busy3_async_rst");
    expect_val(S_MEPC, 32'h0, "mepc_async_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
